// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub result path: the record layout,
// the operation codes and the accumulator FSM states.
package addsub_pkg;

    localparam int unsigned REC_W = 6;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StHold
    } state_e;

    typedef struct packed {
        logic       op;
        logic       cy;
        logic [3:0] f;
    } rec_t;

endpackage

// File: rtl/sm_to_twos.sv
// Combinational decoder from an add/sub result record {op, cy, f} to a 6-bit
// two's-complement value.
module sm_to_twos
    import addsub_pkg::*;
(
    input  rec_t                    rec,
    output logic signed [REC_W-1:0] val
);

    always_comb begin
        val = '0;
        if (rec.op == OP_ADD) begin
            val = {1'b0, rec.cy, rec.f};
        end else if (rec.cy) begin
            // Negative zero (cy=1, f=0) falls out as 0.
            val = -$signed({2'b00, rec.f});
        end else begin
            val = {2'b00, rec.f};
        end
    end

endmodule

// File: rtl/addsub_result_accumulator.sv
// Saturating accumulator over decoded add/sub result records; emits one
// {sum, count, sat} beat per batch on flush or when the record count fills.
module addsub_result_accumulator
    import addsub_pkg::*;
#(
    parameter int unsigned ACC_W = 10,
    parameter int unsigned CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_op,
    input  logic                    in_cy,
    input  logic [3:0]              in_f,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_sat,
    output logic                    busy
);

    localparam logic [CNT_W-1:0]        CNT_FULL = '1;
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      sat_q, sat_d;
    logic signed [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]          out_count_q, out_count_d;
    logic                      out_sat_q, out_sat_d;

    rec_t                      rec;
    logic signed [REC_W-1:0]   rec_val;
    logic signed [ACC_W:0]     sum_wide;
    logic                      overflow;
    logic signed [ACC_W-1:0]   sum_sat;
    logic                      accept;

    assign rec = {in_op, in_cy, in_f};

    sm_to_twos u_dec (
        .rec (rec),
        .val (rec_val)
    );

    // One guard bit is enough: a 6-bit operand cannot overflow it for ACC_W >= 6.
    assign sum_wide = {acc_q[ACC_W-1], acc_q}
                    + {{(ACC_W+1-REC_W){rec_val[REC_W-1]}}, rec_val};
    assign overflow = sum_wide[ACC_W] != sum_wide[ACC_W-1];

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        if (overflow) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Gated by rst_n so the upstream never sees ready while reset is held.
    assign in_ready  = rst_n && (state_q != StHold);
    assign out_valid = (state_q == StHold);
    assign busy      = (state_q != StIdle);
    assign accept    = in_valid && in_ready;

    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        unique case (state_q)
            StIdle, StAcc: begin
                if (accept) begin
                    acc_d   = sum_sat;
                    cnt_d   = cnt_q + 1'b1;
                    sat_d   = sat_q | overflow;
                    state_d = StAcc;
                end
                if (flush || (accept && cnt_d == CNT_FULL)) begin
                    state_d     = StHold;
                    out_sum_d   = acc_d;
                    out_count_d = cnt_d;
                    out_sat_d   = sat_d;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_addsub_result_accumulator.sv
// Scoreboard bench for addsub_result_accumulator at ACC_W=6, CNT_W=4: directed
// batches push expected beats; a monitor pops and compares on each handshake.
module tb_addsub_result_accumulator;

    localparam int unsigned ACC_W = 6;
    localparam int unsigned CNT_W = 4;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_op;
    logic                    in_cy;
    logic [3:0]              in_f;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0]        out_count;
    logic                    out_sat;
    logic                    busy;

    typedef struct {
        int sum;
        int cnt;
        int sat;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   passed;

    addsub_result_accumulator #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_cy     (in_cy),
        .in_f      (in_f),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic push(input int sum, input int cnt, input int sat);
        exp_t e;
        e.sum = sum;
        e.cnt = cnt;
        e.sat = sat;
        exp_q.push_back(e);
    endtask

    // All driver tasks start and end at posedge+1.
    task automatic send(input logic op, input logic cy, input logic [3:0] f, input logic fl);
        in_valid = 1'b1;
        in_op    = op;
        in_cy    = cy;
        in_f     = f;
        flush    = fl;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic take_beat(input string name);
        int waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!out_valid) check({name, "_timeout"}, 0, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Monitor: compare every accepted result beat against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_sum", int'(out_sum), e.sum);
                    check("beat_count", int'(out_count), e.cnt);
                    check("beat_sat", int'(out_sat), e.sat);
                end
            end
        end
    end

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_cy     = 1'b0;
        in_f      = 4'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_sat", int'(out_sat), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", int'(in_ready), 1);

        // Mixed batch: +26, -5, +5
        send(1'b0, 1'b1, 4'b1010, 1'b0);
        send(1'b1, 1'b1, 4'b0101, 1'b0);
        send(1'b1, 1'b0, 4'b0101, 1'b0);
        check("mixed_no_early_valid", int'(out_valid), 0);
        do_flush();
        check("mixed_valid_after_flush", int'(out_valid), 1);
        check("mixed_in_ready_hold", int'(in_ready), 0);
        push(26, 3, 0);
        take_beat("mixed");
        check("mixed_idle_busy", int'(busy), 0);
        check("mixed_idle_ready", int'(in_ready), 1);

        // Empty flush from IDLE
        do_flush();
        check("empty_valid", int'(out_valid), 1);
        push(0, 0, 0);
        take_beat("empty");
        check("empty_busy_after", int'(busy), 0);

        // Positive saturation: 30 + 30 -> 31
        send(1'b0, 1'b1, 4'b1110, 1'b0);
        send(1'b0, 1'b1, 4'b1110, 1'b0);
        do_flush();
        push(31, 2, 1);
        take_beat("sat_pos");

        // Negative saturation: 3 x -15 -> -32
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 4'b1111, 1'b0);
        do_flush();
        push(-32, 3, 1);
        take_beat("sat_neg");

        // Count full: 15 x +1 closes the batch on its own
        for (int i = 0; i < 15; i++) send(1'b0, 1'b0, 4'b0001, 1'b0);
        check("full_auto_valid", int'(out_valid), 1);
        check("full_out_count", int'(out_count), 15);
        push(15, 15, 0);
        in_valid = 1'b1;
        in_op    = 1'b0;
        in_cy    = 1'b0;
        in_f     = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            check("full_16th_blocked", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        take_beat("full");
        check("full_ready_after", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        do_flush();
        push(2, 1, 0);
        take_beat("after_full");

        // Backpressure: outputs frozen, flush ignored while held
        send(1'b0, 1'b0, 4'b0011, 1'b0);
        do_flush();
        push(3, 1, 0);
        for (int i = 0; i < 4; i++) begin
            flush = (i % 2 == 0);
            check("bp_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_sum", int'(out_sum), 3);
            check("bp_count", int'(out_count), 1);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        take_beat("bp");
        check("bp_no_reflush", int'(out_valid), 0);

        // Accept and flush together: record included
        send(1'b0, 1'b0, 4'b0100, 1'b0);
        send(1'b0, 1'b0, 4'b0001, 1'b1);
        check("overlap_valid", int'(out_valid), 1);
        push(5, 2, 0);
        take_beat("overlap");

        // Reset mid-batch discards the batch immediately
        send(1'b0, 1'b0, 4'b0110, 1'b0);
        send(1'b1, 1'b1, 4'b0010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_out_sum", int'(out_sum), 0);
        check("mid_rst_out_count", int'(out_count), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(1'b1, 1'b0, 4'b0111, 1'b0);
        do_flush();
        push(7, 1, 0);
        take_beat("post_rst");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
